// File: rtl/i2srx_pkg.sv
// Shared types and widths for the I2S receiver: FSM encoding, channel/pair widths,
// and the saturating magnitude helper used by the peak meters.
package i2srx_pkg;

    localparam int CH_W   = 16;
    localparam int PAIR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    // |-32768| has no positive 16-bit representation, so it saturates to 32767.
    function automatic logic [CH_W-1:0] abs_sat(input logic [CH_W-1:0] s);
        if (!s[CH_W-1])
            return s;
        else if (s == {1'b1, {(CH_W-1){1'b0}}})
            return {1'b0, {(CH_W-1){1'b1}}};
        else
            return (~s) + CH_W'(1);
    endfunction

endpackage

// File: rtl/i2srx_fifo.sv
// First-word-fall-through pair FIFO with an explicit full flag; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module i2srx_fifo
    import i2srx_pkg::*;
#(
    parameter int WIDTH = PAIR_W,
    parameter int DEPTH = 4
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             wr_ok
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_nxt;
    logic [AW-1:0]    rd_nxt;
    logic             full;
    logic             do_rd;

    assign do_rd    = pop & ~empty;
    assign wr_ok    = push & (~full | do_rd);
    assign wr_nxt   = wr_ptr + AW'(1);
    assign rd_nxt   = rd_ptr + AW'(1);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clkin) begin
        if (wr_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_nxt;
            if (do_rd)
                rd_ptr <= rd_nxt;
            // Simultaneous push and pop leaves occupancy, and therefore both flags, unchanged.
            if (wr_ok && !do_rd) begin
                empty <= 1'b0;
                full  <= (wr_nxt == rd_ptr);
            end else if (do_rd && !wr_ok) begin
                full  <= 1'b0;
                empty <= (rd_nxt == wr_ptr);
            end
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the external bit/word clocks, deserializes 16-bit stereo
// pairs into a FWFT FIFO. Define I2SRX_PEAK_EN to add per-channel peak meters.
//
//   state | meaning
//   IDLE  | waiting for an lrck 1->0 edge while enabled
//   LEFT  | shifting left-channel bits (lrck low)
//   RIGHT | shifting right-channel bits (lrck high); 16th bit completes the pair
module i2s_rx
    import i2srx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic              clkin,
    input  logic              reset_n,
    input  logic              sclk_in,
    input  logic              lrck_in,
    input  logic              sdin,
    input  logic              enable,
    output logic [PAIR_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    input  logic              clear_ovf,
    output logic              frame_err
`ifdef I2SRX_PEAK_EN
    ,
    output logic [CH_W-1:0]   peak_l,
    output logic [CH_W-1:0]   peak_r,
    input  logic              peak_clr
`endif
);

    localparam logic [4:0] BITS_INIT = 5'(CH_W);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;

    rx_state_t         state;
    logic [4:0]        cnt;
    logic [CH_W-1:0]   shreg;
    logic [CH_W-1:0]   left_word;
    logic              pair_ok;
    logic              lrck_prev;
    logic              push_req;
    logic [PAIR_W-1:0] push_word;

    logic              rise;
    logic              lrck_s;
    logic              sdin_s;
    logic              lr_edge;
    logic              take_bit;
    logic [4:0]        cnt_after;
    logic [CH_W-1:0]   word_after;
    logic              fifo_empty;
    logic              wr_ok;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            lrck_sync <= '0;
            sdin_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
        end
    end

    always_comb begin
        rise       = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES-2];
        lrck_s     = lrck_sync[SYNC_STAGES-1];
        sdin_s     = sdin_sync[SYNC_STAGES-1];
        lr_edge    = lrck_s ^ lrck_prev;
        take_bit   = (cnt != 5'd0);
        cnt_after  = take_bit ? cnt - 5'd1 : 5'd0;
        word_after = take_bit ? {shreg[CH_W-2:0], sdin_s} : shreg;
    end

    // The rise that sees an lrck edge still carries the previous channel's last bit,
    // so the bit is shifted in before the channel-length check.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            shreg     <= '0;
            left_word <= '0;
            pair_ok   <= 1'b0;
            lrck_prev <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= frame_err & ~clear_ovf;
            if (rise)
                lrck_prev <= lrck_s;
            if (!enable) begin
                state <= IDLE;
            end else if (rise) begin
                case (state)
                    IDLE: begin
                        if (lrck_prev && !lrck_s) begin
                            state   <= LEFT;
                            cnt     <= BITS_INIT;
                            shreg   <= '0;
                            pair_ok <= 1'b1;
                        end
                    end
                    LEFT, RIGHT: begin
                        shreg <= word_after;
                        cnt   <= cnt_after;
                        if (cnt == 5'd1) begin
                            if (state == LEFT) begin
                                left_word <= word_after;
                            end else if (pair_ok) begin
                                push_req  <= 1'b1;
                                push_word <= {word_after, left_word};
                            end
                        end
                        if (lr_edge) begin
                            cnt   <= BITS_INIT;
                            shreg <= '0;
                            if (cnt_after != 5'd0)
                                frame_err <= 1'b1;
                            if (state == LEFT) begin
                                state   <= RIGHT;
                                pair_ok <= pair_ok & (cnt_after == 5'd0);
                            end else begin
                                state   <= LEFT;
                                pair_ok <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else
            overflow <= (overflow & ~clear_ovf) | (push_req & ~wr_ok);
    end

    i2srx_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (push_word),
        .pop       (sample_ready),
        .pop_data  (sample_data),
        .empty     (fifo_empty),
        .wr_ok     (wr_ok)
    );

    assign sample_valid = ~fifo_empty;

`ifdef I2SRX_PEAK_EN
    logic [CH_W-1:0] mag_l;
    logic [CH_W-1:0] mag_r;

    assign mag_l = abs_sat(push_word[CH_W-1:0]);
    assign mag_r = abs_sat(push_word[PAIR_W-1:CH_W]);

    // A clear coinciding with an accepted pair restarts the meters from that pair.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            peak_l <= '0;
            peak_r <= '0;
        end else if (wr_ok) begin
            peak_l <= (peak_clr || mag_l > peak_l) ? mag_l : peak_l;
            peak_r <= (peak_clr || mag_r > peak_r) ? mag_r : peak_r;
        end else if (peak_clr) begin
            peak_l <= '0;
            peak_r <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit-level I2S frames driven on clkin negedges, checks via
// immediate assertions. Peak-meter steps are included when I2SRX_PEAK_EN is defined.
module tb_i2s_rx;

    logic        clkin        = 1'b0;
    logic        reset_n      = 1'b0;
    logic        sclk_in      = 1'b0;
    logic        lrck_in      = 1'b1;
    logic        sdin         = 1'b0;
    logic        enable       = 1'b1;
    logic        sample_ready = 1'b0;
    logic        clear_ovf    = 1'b0;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        overflow;
    logic        frame_err;
`ifdef I2SRX_PEAK_EN
    logic [15:0] peak_l;
    logic [15:0] peak_r;
    logic        peak_clr = 1'b0;
`endif

    int          checks  = 0;
    int          failures = 0;
    int          pop_cnt = 0;
    int          p0;
    logic [31:0] last_pop = '0;

    always #5 clkin = ~clkin;

    i2s_rx dut (
        .clkin        (clkin),
        .reset_n      (reset_n),
        .sclk_in      (sclk_in),
        .lrck_in      (lrck_in),
        .sdin         (sdin),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf),
        .frame_err    (frame_err)
`ifdef I2SRX_PEAK_EN
        ,
        .peak_l       (peak_l),
        .peak_r       (peak_r),
        .peak_clr     (peak_clr)
`endif
    );

    // Pops are recorded midway between the input-drive point and the next posedge.
    always @(negedge clkin) begin
        #3;
        if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
            pop_cnt++;
            last_pop = sample_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clkin);
        #1;
    endtask

    // One sclk period; pp pulses sample_ready so it is sampled on the FIFO push cycle.
    task automatic sclk_bit(input logic lr, input logic d, input logic pp);
        lrck_in = lr;
        sdin    = d;
        wait_clk(8);
        sclk_in = 1'b1;
        if (pp) begin
            wait_clk(3);
            sample_ready = 1'b1;
            wait_clk(1);
            sample_ready = 1'b0;
            wait_clk(4);
        end else begin
            wait_clk(8);
        end
        sclk_in = 1'b0;
    endtask

    // Slot index 0 is the rise that sees the lrck change; indices 1..16 carry MSB..LSB.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int first,
                             input int last, input int pp_idx);
        for (int i = first; i <= last; i++)
            sclk_bit(lr, (i >= 1 && i <= 16) ? w[16-i] : 1'b0, i == pp_idx);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 0, 17, -1);
        send_slot(1'b1, r, 0, 17, -1);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, " valid"}, {31'd0, sample_valid}, 32'd1);
        check({tag, " data"}, sample_data, exp);
        sample_ready = 1'b1;
        wait_clk(1);
        sample_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_ovf = 1'b1;
        wait_clk(1);
        clear_ovf = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        wait_clk(3);
        check("rst valid", {31'd0, sample_valid}, 32'd0);
        check("rst data", sample_data, 32'd0);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        check("rst frame_err", {31'd0, frame_err}, 32'd0);
`ifdef I2SRX_PEAK_EN
        check("rst peak_l", {16'd0, peak_l}, 32'd0);
        check("rst peak_r", {16'd0, peak_r}, 32'd0);
`endif
        reset_n = 1'b1;
        wait_clk(2);
        send_slot(1'b1, 16'h0000, 0, 3, -1);

        // Single frame with the consumer always ready.
        p0 = pop_cnt;
        sample_ready = 1'b1;
        send_frame(16'h1234, 16'hFEDC);
        wait_clk(4);
        sample_ready = 1'b0;
        check("t1 pops", pop_cnt - p0, 32'd1);
        check("t1 data", last_pop, 32'hFEDC1234);
        check("t1 valid after", {31'd0, sample_valid}, 32'd0);
        check("t1 frame_err", {31'd0, frame_err}, 32'd0);

        // Five frames into a four-deep FIFO: the fifth is dropped.
        for (int k = 0; k < 5; k++)
            send_frame(16'(32'h1000 + k), 16'(32'h2000 + k));
        check("t2 overflow", {31'd0, overflow}, 32'd1);
        for (int k = 0; k < 4; k++)
            pop_check($sformatf("t2 pop%0d", k), {16'(32'h2000 + k), 16'(32'h1000 + k)});
        check("t2 fifth absent", {31'd0, sample_valid}, 32'd0);
        pulse_clear();
        check("t2 overflow cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO, push and pop land on the same cycle.
        for (int k = 0; k < 4; k++)
            send_frame(16'(32'h3000 + k), 16'(32'h4000 + k));
        check("t3 overflow before", {31'd0, overflow}, 32'd0);
        p0 = pop_cnt;
        send_slot(1'b0, 16'h3004, 0, 17, -1);
        send_slot(1'b1, 16'h4004, 0, 17, 16);
        check("t3 overflow", {31'd0, overflow}, 32'd0);
        check("t3 pops", pop_cnt - p0, 32'd1);
        check("t3 popped head", last_pop, 32'h40003000);
        for (int k = 1; k < 5; k++)
            pop_check($sformatf("t3 pop%0d", k), {16'(32'h4000 + k), 16'(32'h3000 + k)});
        check("t3 empty", {31'd0, sample_valid}, 32'd0);

        // Left channel cut short after 10 bits.
        send_slot(1'b0, 16'hAAAA, 0, 10, -1);
        send_slot(1'b1, 16'h5555, 0, 17, -1);
        check("t4 frame_err", {31'd0, frame_err}, 32'd1);
        check("t4 no push", {31'd0, sample_valid}, 32'd0);
        pulse_clear();
        check("t4 frame_err cleared", {31'd0, frame_err}, 32'd0);
        send_frame(16'h1357, 16'h2468);
        pop_check("t4 next frame", 32'h24681357);
        check("t4 frame_err after", {31'd0, frame_err}, 32'd0);

        // Enable dropped after 8 left bits, restored mid-slot.
        send_slot(1'b0, 16'h1111, 0, 8, -1);
        enable = 1'b0;
        send_slot(1'b0, 16'h1111, 9, 12, -1);
        enable = 1'b1;
        send_slot(1'b0, 16'h1111, 13, 17, -1);
        send_slot(1'b1, 16'h2222, 0, 17, -1);
        check("t5 no push", {31'd0, sample_valid}, 32'd0);
        check("t5 frame_err", {31'd0, frame_err}, 32'd0);
        send_frame(16'h3333, 16'h4444);
        check("t5 valid", {31'd0, sample_valid}, 32'd1);
        check("t5 data", sample_data, 32'h44443333);

        // Reset mid-frame with a pending pair and a sticky frame error.
        send_slot(1'b0, 16'h0F0F, 0, 5, -1);
        send_slot(1'b1, 16'h0F0F, 0, 17, -1);
        check("t6 frame_err set", {31'd0, frame_err}, 32'd1);
        send_slot(1'b0, 16'h5A5A, 0, 6, -1);
        reset_n = 1'b0;
        wait_clk(2);
        check("t6 rst valid", {31'd0, sample_valid}, 32'd0);
        check("t6 rst data", sample_data, 32'd0);
        check("t6 rst frame_err", {31'd0, frame_err}, 32'd0);
        check("t6 rst overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        send_slot(1'b0, 16'h5A5A, 7, 17, -1);
        send_slot(1'b1, 16'hA5A5, 0, 17, -1);
        check("t6 no push", {31'd0, sample_valid}, 32'd0);
        check("t6 frame_err after", {31'd0, frame_err}, 32'd0);
        send_frame(16'h6666, 16'h7777);
`ifdef I2SRX_PEAK_EN
        check("t7 peak_l pre", {16'd0, peak_l}, 32'h6666);
        check("t7 peak_r pre", {16'd0, peak_r}, 32'h7777);
`endif
        pop_check("t6 next frame", 32'h77776666);

`ifdef I2SRX_PEAK_EN
        peak_clr = 1'b1;
        wait_clk(1);
        peak_clr = 1'b0;
        check("t7 peak_l clr0", {16'd0, peak_l}, 32'd0);
        check("t7 peak_r clr0", {16'd0, peak_r}, 32'd0);
        send_frame(16'h8000, 16'h0100);
        send_frame(16'h7000, 16'hFF00);
        check("t7 peak_l", {16'd0, peak_l}, 32'h7FFF);
        check("t7 peak_r", {16'd0, peak_r}, 32'h0100);
        pop_check("t7 pop0", 32'h01008000);
        pop_check("t7 pop1", 32'hFF007000);
        peak_clr = 1'b1;
        wait_clk(1);
        peak_clr = 1'b0;
        check("t7 peak_l clr", {16'd0, peak_l}, 32'd0);
        check("t7 peak_r clr", {16'd0, peak_r}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
